// File: rtl/vga_frame_probe_pkg.sv
// vga_frame_probe shared definitions: probe states, PMOD bit positions,
// default 640x480 timing and CRC-16-CCITT constants.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } probe_state_t;

    // TinyVGA PMOD byte layout {hsync, B0, G0, R0, vsync, B1, G1, R1}
    localparam int PMOD_HSYNC = 7;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_R1    = 0;

    localparam int DEF_H_START  = 144;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_START  = 35;
    localparam int DEF_V_ACTIVE = 480;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/vga_frame_probe_if.sv
// Probe bus: PMOD byte in, recovered pixel stream and frame status out.
// master = the VGA source / bench side, slave = the probe.
interface vga_frame_probe_if;
    import vga_timing_pkg::*;

    logic [7:0]  vga_in;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [5:0]  pix_rgb;
    logic        locked;
    logic        frame_done;
    logic [15:0] frame_crc;
    logic [10:0] h_total;
    logic [9:0]  v_total;
    logic        sync_err;
    logic        blank_err;

    modport master (
        output vga_in,
        input  pix_valid, pix_x, pix_y, pix_rgb, locked, frame_done,
               frame_crc, h_total, v_total, sync_err, blank_err
    );

    modport slave (
        input  vga_in,
        output pix_valid, pix_x, pix_y, pix_rgb, locked, frame_done,
               frame_crc, h_total, v_total, sync_err, blank_err
    );
endinterface

// File: rtl/vga_frame_probe_crc16.sv
// One byte of CRC-16-CCITT (poly 0x1021, MSB first), purely combinational.
module crc16_ccitt_step
    import vga_timing_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);
    // fold the byte into the top and shift out eight bits
    always_comb begin
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end
endmodule

// File: rtl/vga_frame_probe.sv
// vga_frame_probe: passive TinyVGA PMOD receiver. Recovers sync timing,
// locks onto frame geometry, rebuilds pixel coordinates/colour and signs
// each locked frame with CRC-16-CCITT.
// Optional: define VGA_PROBE_BLANK_CHECK_EN to flag colour in blanking.
module vga_frame_probe
    import vga_timing_pkg::*;
#(
    parameter int H_START  = DEF_H_START,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_START  = DEF_V_START,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input logic              clk,
    input logic              reset,
    vga_frame_probe_if.slave bus
);
    localparam logic [10:0] H_LO = 11'(H_START);
    localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_LO = 10'(V_START);
    localparam logic [9:0]  V_HI = 10'(V_START + V_ACTIVE);

    logic [7:0]   s1, s2;
    logic [10:0]  hcnt;
    logic [9:0]   vcnt;
    probe_state_t state, state_nx;
    logic         m_started, m_started_nx, m_haslen, m_haslen_nx;
    logic         latch_h, latch_v, err_nx, done_nx, err_q, done_q;
    logic [10:0]  h_tot;
    logic [9:0]   v_tot;
    logic [15:0]  acc, crc_nx, crc_q;

    // syncs are active-low: an assertion is a 1 -> 0 step between s2 and s1
    wire hs_edge = s2[PMOD_HSYNC] & ~s1[PMOD_HSYNC];
    wire vs_edge = s2[PMOD_VSYNC] & ~s1[PMOD_VSYNC];

    // hcnt is one short of the line length when the closing edge arrives
    wire [10:0] line_len    = hcnt + 11'd1;
    wire [9:0]  frame_lines = vcnt + {9'd0, hs_edge};
    wire        sat         = (hcnt == 11'h7FF) || (vcnt == 10'h3FF);

    wire in_win = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);
    wire pix_ok = (state == ST_LOCKED) && in_win;
    wire [5:0] rgb = {s2[PMOD_R1], s2[PMOD_R0], s2[PMOD_G1],
                      s2[PMOD_G0], s2[PMOD_B1], s2[PMOD_B0]};

    // two-stage input capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.vga_in;
            s2 <= s1;
        end
    end

    // saturating line/frame counters; coincident vsync+hsync leaves vcnt at 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            if (hs_edge)              hcnt <= '0;
            else if (hcnt != 11'h7FF) hcnt <= hcnt + 11'd1;
            if (vs_edge)                     vcnt <= hs_edge ? 10'd1 : 10'd0;
            else if (hs_edge && !sat_v(vcnt)) vcnt <= vcnt + 10'd1;
        end
    end

    function automatic logic sat_v(input logic [9:0] v);
        return v == 10'h3FF;
    endfunction

    // lock state machine: next state and one-cycle strobes
    always_comb begin
        state_nx     = state;
        m_started_nx = m_started;
        m_haslen_nx  = m_haslen;
        latch_h      = 1'b0;
        latch_v      = 1'b0;
        err_nx       = 1'b0;
        done_nx      = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (vs_edge) begin
                    state_nx     = ST_MEASURE;
                    m_started_nx = hs_edge;  // a coincident hsync opens the first line
                    m_haslen_nx  = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (hs_edge) begin
                    if (!m_started) begin
                        m_started_nx = 1'b1;
                    end else if (!m_haslen) begin
                        latch_h     = 1'b1;
                        m_haslen_nx = 1'b1;
                    end else if (line_len != h_tot) begin
                        state_nx = ST_SEARCH;
                    end
                end
                if (vs_edge && state_nx == ST_MEASURE) begin
                    latch_v  = 1'b1;
                    state_nx = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if ((hs_edge && line_len != h_tot) ||
                    (vs_edge && frame_lines != v_tot) || sat) begin
                    state_nx = ST_SEARCH;
                    err_nx   = 1'b1;
                end else if (vs_edge) begin
                    done_nx = 1'b1;
                end
            end
            default: state_nx = ST_SEARCH;
        endcase
    end

    // state, measured geometry and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SEARCH;
            m_started <= 1'b0;
            m_haslen  <= 1'b0;
            h_tot     <= '0;
            v_tot     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            m_started <= m_started_nx;
            m_haslen  <= m_haslen_nx;
            if (latch_h) h_tot <= line_len;
            if (latch_v) v_tot <= frame_lines;
            err_q     <= err_nx;
            done_q    <= done_nx;
        end
    end

    crc16_ccitt_step u_crc (
        .crc_in  (acc),
        .data    ({2'b00, rgb}),
        .crc_out (crc_nx)
    );

    // frame signature: restart on lock, publish and restart on each good vsync
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= CRC_INIT;
            crc_q <= '0;
        end else if (state != ST_LOCKED && state_nx == ST_LOCKED) begin
            acc <= CRC_INIT;
        end else if (done_nx) begin
            crc_q <= acc;
            acc   <= CRC_INIT;
        end else if (pix_ok) begin
            acc <= crc_nx;
        end
    end

`ifdef VGA_PROBE_BLANK_CHECK_EN
    logic blank_q;
    // sticky colour-in-blanking flag, cleared by frame_done unless re-set
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          blank_q <= 1'b0;
        else if (state == ST_LOCKED && !in_win && rgb != 6'd0) blank_q <= 1'b1;
        else if (done_q)                                    blank_q <= 1'b0;
    end
    assign bus.blank_err = blank_q;
`else
    assign bus.blank_err = 1'b0;
`endif

    assign bus.pix_valid  = pix_ok;
    assign bus.pix_x      = pix_ok ? 10'(hcnt - H_LO) : 10'd0;
    assign bus.pix_y      = pix_ok ? (vcnt - V_LO) : 10'd0;
    assign bus.pix_rgb    = pix_ok ? rgb : 6'd0;
    assign bus.locked     = (state == ST_LOCKED);
    assign bus.frame_done = done_q;
    assign bus.frame_crc  = crc_q;
    assign bus.h_total    = h_tot;
    assign bus.v_total    = v_tot;
    assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_vga_frame_probe.sv
// Bench for vga_frame_probe on a reduced 16x8 geometry (8x4 active,
// hsync at hpos 12-13, vsync for the line two before the frame end).
module tb_vga_frame_probe;
    localparam int HS = 4, HA = 8, VS = 2, VA = 4;
`ifdef VGA_PROBE_BLANK_CHECK_EN
    localparam int BLK = 1;
`else
    localparam int BLK = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_frame_probe_if bus ();

    vga_frame_probe #(.H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int nl; int stretch; int mode; int bl;
        int exp_done; int exp_err; int exp_lock; int exp_blank;
    } vec_t;

    int n_chk = 0, n_pass = 0;
    int cur_mode = 0;
    logic [15:0] gold [3];

    // monitor state (written only by the monitor process)
    int fd_cnt = 0, se_cnt = 0, run_pv = 0, run_bad = 0, f_pv = 0, f_bad = 0;
    int run_fx = 0, run_fy = 0, run_lx = 0, run_ly = 0;
    int f_fx = 0, f_fy = 0, f_lx = 0, f_ly = 0;
    logic [15:0] f_crc = '0;
    bit have_first = 0, locked_d = 0;

    function automatic logic [5:0] col(input int m, input int x, input int y);
        if (m == 1) return 6'(x);
        if (m == 2) return 6'(x * 5 + y * 17 + 3);
        return 6'd0;
    endfunction

    function automatic logic [7:0] enc(input logic hs, input logic vs, input logic [5:0] c);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

    // bit-serial reference CRC
    function automatic logic [15:0] crc_m(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic send_frame(input int nl, input int stretch, input int mode, input int bl,
                              input int l0, input int l1);
        for (int l = l0; l < l1; l++) begin
            int len;
            len = (l == stretch) ? 17 : 16;
            for (int h = 0; h < len; h++) begin
                logic hs, vs;
                logic [5:0] c;
                hs = !(h == 12 || h == 13);
                vs = (l != nl - 2);
                if (l < 4 && h < 8)         c = col(mode, h, l);
                else if (l == bl && h == 14) c = 6'b110000;
                else                         c = 6'd0;
                @(negedge clk);
                bus.vga_in = enc(hs, vs, c);
            end
        end
    endtask

    // pixel/frame monitor, sampled 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.frame_done) begin
                fd_cnt++;
                f_pv = run_pv; f_bad = run_bad; f_crc = bus.frame_crc;
                f_fx = run_fx; f_fy = run_fy; f_lx = run_lx; f_ly = run_ly;
                run_pv = 0; run_bad = 0; have_first = 0;
            end
            if (bus.sync_err) se_cnt++;
            if (bus.locked && !locked_d) begin
                run_pv = 0; run_bad = 0; have_first = 0;
            end
            locked_d = bus.locked;
            if (bus.pix_valid) begin
                if (!have_first) begin
                    run_fx = int'(bus.pix_x); run_fy = int'(bus.pix_y); have_first = 1;
                end
                run_lx = int'(bus.pix_x); run_ly = int'(bus.pix_y);
                run_pv++;
                if (bus.pix_rgb != col(cur_mode, int'(bus.pix_x), int'(bus.pix_y))) run_bad++;
            end
        end
    end

    task automatic check_frame(input string tag, input int mode);
        check({tag, " pix count"}, f_pv, HA * VA);
        check({tag, " first x"}, f_fx, 0);
        check({tag, " first y"}, f_fy, 0);
        check({tag, " last x"}, f_lx, HA - 1);
        check({tag, " last y"}, f_ly, VA - 1);
        check({tag, " rgb errors"}, f_bad, 0);
        check({tag, " frame_crc"}, f_crc, gold[mode]);
    endtask

    initial begin
        vec_t vt [15];
        int fd0, se0;

        for (int m = 0; m < 3; m++) begin
            gold[m] = 16'hFFFF;
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++)
                    gold[m] = crc_m(gold[m], {2'b00, col(m, x, y)});
        end

        //        nl stretch mode bl  done err lock blank
        vt[0]  = '{8, -1, 0, -1, 0, 0, 0, 0};   // SEARCH -> MEASURE
        vt[1]  = '{8, -1, 0, -1, 0, 0, 1, 0};   // -> LOCKED
        vt[2]  = '{8, -1, 0, -1, 1, 0, 1, 0};   // black frame
        vt[3]  = '{8, -1, 1, -1, 1, 0, 1, 0};   // colour = x
        vt[4]  = '{8, -1, 1, -1, 1, 0, 1, 0};   // same again
        vt[5]  = '{8, -1, 2, -1, 1, 0, 1, 0};   // mixed colour
        vt[6]  = '{8,  1, 2, -1, 0, 1, 0, 0};   // 17-clock line
        vt[7]  = '{8, -1, 0, -1, 0, 0, 1, 0};   // relock
        vt[8]  = '{8, -1, 0, -1, 1, 0, 1, 0};
        vt[9]  = '{8, -1, 1, -1, 1, 0, 1, 0};
        vt[10] = '{7, -1, 1, -1, 0, 1, 0, 0};   // one line short
        vt[11] = '{8, -1, 0, -1, 0, 0, 0, 0};
        vt[12] = '{8, -1, 0, -1, 0, 0, 1, 0};
        vt[13] = '{8, -1, 2,  7, 1, 0, 1, BLK}; // colour in blanking after vsync
        vt[14] = '{8, -1, 2, -1, 1, 0, 1, 0};   // cleared by frame_done

        reset = 1'b1;
        bus.vga_in = enc(1'b1, 1'b1, 6'd0);
        repeat (3) @(negedge clk);
        check("rst locked", bus.locked, 0);
        check("rst pix_valid", bus.pix_valid, 0);
        check("rst h_total", bus.h_total, 0);
        check("rst v_total", bus.v_total, 0);
        check("rst frame_crc", bus.frame_crc, 0);
        check("rst frame_done", bus.frame_done, 0);
        check("rst sync_err", bus.sync_err, 0);
        check("rst blank_err", bus.blank_err, 0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            fd0 = fd_cnt; se0 = se_cnt; cur_mode = vt[i].mode;
            send_frame(vt[i].nl, vt[i].stretch, vt[i].mode, vt[i].bl, 0, vt[i].nl);
            check({tag, " frame_done pulses"}, fd_cnt - fd0, vt[i].exp_done);
            check({tag, " sync_err pulses"}, se_cnt - se0, vt[i].exp_err);
            check({tag, " locked"}, bus.locked, vt[i].exp_lock);
            check({tag, " h_total"}, bus.h_total, 16);
            check({tag, " v_total"}, bus.v_total, (i == 0) ? 0 : 8);
            check({tag, " blank_err"}, bus.blank_err, vt[i].exp_blank);
            if (vt[i].exp_done != 0) check_frame(tag, vt[i].mode);
        end

        // reset a few pixels into active line 2 of a locked frame
        fd0 = fd_cnt; se0 = se_cnt; cur_mode = 1;
        send_frame(8, -1, 1, -1, 0, 2);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            bus.vga_in = enc(1'b1, 1'b1, col(1, h, 2));
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid rst locked", bus.locked, 0);
        check("mid rst pix_valid", bus.pix_valid, 0);
        check("mid rst pix_rgb", bus.pix_rgb, 0);
        check("mid rst pix_x", bus.pix_x, 0);
        check("mid rst h_total", bus.h_total, 0);
        check("mid rst v_total", bus.v_total, 0);
        check("mid rst frame_crc", bus.frame_crc, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        send_frame(8, -1, 1, -1, 2, 8);
        check("after rst locked", bus.locked, 0);
        check("after rst h_total", bus.h_total, 16);
        send_frame(8, -1, 1, -1, 0, 8);
        check("relock locked", bus.locked, 1);
        check("relock no frame_done", fd_cnt - fd0, 0);
        check("relock no sync_err", se_cnt - se0, 0);
        send_frame(8, -1, 1, -1, 0, 8);
        check("post rst frame_done", fd_cnt - fd0, 1);
        check_frame("post rst", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
